// File: rtl/magcompare_seq_if.sv
// Operand/result bundle for the serial magnitude comparator.
// master drives the request side, slave is the comparator itself.
interface magcompare_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             LT;
  logic             GT;
  logic             EQ;

  modport master (
    output start, A, B,
    input  busy, done, LT, GT, EQ
  );

  modport slave (
    input  start, A, B,
    output busy, done, LT, GT, EQ
  );
endinterface

// File: rtl/magcompare_seq.sv
// Serial unsigned magnitude comparator, 2 bits per cycle, MSB slice first.
// Optional macro MAGSEQ_EARLY_EXIT_EN finishes as soon as a slice differs.
module magcompare2b (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       lt_o,
  output logic       gt_o,
  output logic       eq_o
);
  always_comb begin
    lt_o = (~a_i[1] & b_i[1]) | ((a_i[1] ~^ b_i[1]) & ~a_i[0] & b_i[0]);
    gt_o = (a_i[1] & ~b_i[1]) | ((a_i[1] ~^ b_i[1]) & a_i[0] & ~b_i[0]);
    eq_o = (a_i == b_i);
  end
endmodule

module magcompare_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  magcompare_seq_if.slave   bus
);
  localparam int unsigned Slices = WIDTH / 2;
  localparam int unsigned CntW   = (Slices > 1) ? $clog2(Slices) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
    $error("magcompare_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dec_q, dec_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic [1:0] a_slice, b_slice;
  logic       cell_lt, cell_gt, cell_eq;
  logic       slice_decides;

  always_comb begin
    a_slice = a_q[{cnt_q, 1'b0} +: 2];
    b_slice = b_q[{cnt_q, 1'b0} +: 2];
  end

  magcompare2b u_cell (
    .a_i  (a_slice),
    .b_i  (b_slice),
    .lt_o (cell_lt),
    .gt_o (cell_gt),
    .eq_o (cell_eq)
  );

  // Only the first differing slice counts; later ones are don't-care.
  assign slice_decides = ~dec_q & ~cell_eq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = CntW'(Slices - 1);
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (slice_decides) begin
          dec_d = 1'b1;
          lt_d  = cell_lt;
          gt_d  = cell_gt;
        end
`ifdef MAGSEQ_EARLY_EXIT_EN
        if (slice_decides) begin
          state_d = StDone;
        end
`endif
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!dec_q && cell_eq) begin
            eq_d = 1'b1;
            lt_d = 1'b0;
            gt_d = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Partial results stay hidden while the compare is still running.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
    bus.LT   = lt_q & (state_q != StRun);
    bus.GT   = gt_q & (state_q != StRun);
    bus.EQ   = eq_q & (state_q != StRun);
  end
endmodule

// File: tb/tb_magcompare_seq.sv
// Scoreboard bench for magcompare_seq: expected results queued at launch,
// checked against each done pulse together with its cycle of arrival.
module tb_magcompare_seq;
  localparam int unsigned W = 16;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    int   dc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t last_e;

  magcompare_seq_if #(.WIDTH(W)) bus ();

  magcompare_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAGSEQ_EARLY_EXIT_EN
    for (int i = 0; i < W / 2; i++) begin
      if (a[W-1-2*i -: 2] != b[W-1-2*i -: 2]) return i + 2;
    end
`endif
    return W / 2 + 1;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int sc);
    exp_t e;
    e.lt = (a < b);
    e.gt = (a > b);
    e.eq = (a == b);
    e.dc = sc + latency(a, b);
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check_val("spurious_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("lt", bus.LT, mon_e.lt);
          check_val("gt", bus.GT, mon_e.gt);
          check_val("eq", bus.EQ, mon_e.eq);
          check_val("done_cycle", cyc, mon_e.dc);
        end
      end else if (bus.busy) begin
        check_val("masked_in_run", {bus.LT, bus.GT, bus.EQ}, 0);
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    last_e = model(a, b, cyc);
    sb.push_back(last_e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check_val("timeout", 1, 0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] exp);
    @(negedge clk);
    check_val(tag, {bus.busy, bus.done, bus.LT, bus.GT, bus.EQ}, {27'd0, exp});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    exp_t e1, e2;
    int p;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    check_outputs("reset_state", 5'b00000);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    launch(16'h1234, 16'h1234);
    wait_done();
    launch(16'h8000, 16'h4000);
    wait_done();
    launch(16'h00F1, 16'h00F2);
    wait_done();
    repeat (3) @(posedge clk);
    check_outputs("idle_hold", {2'b00, last_e.lt, last_e.gt, last_e.eq});

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = (i % 2 == 0) ? {ra[15:8], 8'($urandom)} : W'($urandom);
      launch(ra, rb);
      wait_done();
    end
    launch(16'hFFFF, 16'hFFFF);
    wait_done();
    launch(16'h0000, 16'h0001);
    wait_done();

    // Start while busy must be dropped without a second done.
    launch(16'h1234, 16'h1234);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A = 16'hFFFF;
    bus.B = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (12) @(posedge clk);

    // Reset partway through a run aborts it silently.
    launch(16'h5555, 16'h5555);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("after_abort", 5'b00000);
    repeat (12) @(posedge clk);
    launch(16'd3, 16'd5);
    wait_done();

    // Start held across two compares; operands change after first capture.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A = 16'h8000;
    bus.B = 16'h4000;
    p = cyc;
    e1 = model(16'h8000, 16'h4000, p);
    e2 = model(16'h00F1, 16'h00F2, e1.dc + 1);
    sb.push_back(e1);
    sb.push_back(e2);
    @(posedge clk);
    #1;
    bus.A = 16'h00F1;
    bus.B = 16'h00F2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 16'hAAAA;
    wait_done();

    repeat (12) @(posedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
